dbus_sram_bridge: RTL and testbench



---
 rtl/dbus_sram_bridge_pkg.sv | 24 ++
 rtl/bus_timeout_counter.sv | 28 ++
 rtl/dbus_sram_bridge.sv | 126 ++++++++++++
 tb/tb_dbus_sram_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_sram_bridge_pkg.sv
// Shared types for the data-side SRAM-port to valid/ready bus bridge.
// Holds the bridge state encoding and the latched request record.
package dbus_sram_bridge_pkg;

    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;
    localparam int W_STRB = W_DATA / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } dbus_state_t;

    typedef struct packed {
        logic              write;
        logic [W_STRB-1:0] wstrb;
        logic [W_ADDR-1:0] addr;
        logic [W_DATA-1:0] wdata;
    } dbus_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts response-wait cycles and flags the last permitted one.
// TIMEOUT = 0 disables expiry entirely.
module bus_timeout_counter #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expire = (TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/dbus_sram_bridge.sv
// Turns a single-shot MM-stage SRAM access into one valid/ready bus
// transaction, stalling the pipe until it completes and holding read data for WB.
module dbus_sram_bridge
    import dbus_sram_bridge_pkg::*;
#(
    parameter int ADDR_W  = W_ADDR,
    parameter int DATA_W  = W_DATA,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [3:0]        req_wstrb,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_err
);

    dbus_state_t state, state_nxt;
    dbus_req_t   req_q;
    logic        timed_out_q;
    logic        cnt_clear, cnt_en, expire;

    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expire (expire)
    );

    // NOTE: every register here, data included, is cleared by the synchronous
    // reset so an abandoned transaction leaves no stale read data behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            timed_out_q <= 1'b0;
            cpu_rdata   <= '0;
            cpu_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            state   <= state_nxt;
            cpu_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_en) begin
                        req_q <= '{write: |cpu_we, wstrb: cpu_we,
                                   addr: cpu_addr, wdata: cpu_wdata};
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid) begin
                        if (!req_q.write) begin
                            cpu_rdata <= rsp_err ? '0 : rsp_data;
                        end
                        timed_out_q <= 1'b0;
                        cpu_err     <= rsp_err;
                    end else if (expire) begin
                        timed_out_q <= 1'b1;
                        cpu_err     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_nxt = state;
        cpu_stall = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_stall = cpu_en;
                if (cpu_en) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                req_valid = 1'b1;
                cpu_stall = 1'b1;
                if (req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                rsp_ready = 1'b1;
                cpu_stall = 1'b1;
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                if (rsp_valid || expire) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // The CPU keeps presenting the finished access here; it is never reissued.
                if (!cpu_hold) state_nxt = timed_out_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                // Swallow the late response of a timed-out access before starting anew.
                rsp_ready = 1'b1;
                cpu_stall = cpu_en;
                if (rsp_valid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req_write = req_q.write;
    assign req_wstrb = req_q.wstrb;
    assign req_addr  = req_q.addr;
    assign req_wdata = req_q.wdata;

endmodule

// File: tb/tb_dbus_sram_bridge.sv
// Self-checking bench for dbus_sram_bridge: directed and random accesses
// against a transaction-level model of stall length, errors and read data.
module tb_dbus_sram_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_hold;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    dbus_sram_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_hold  (cpu_hold),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_err   (cpu_err),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_wstrb (req_wstrb),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata;
    bit          late_pending;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One CPU access. Bus slave: accepts the request after rdy_dly REQ cycles and
    // answers after rsp_dly WAIT cycles (rsp_dly >= TMO means never, i.e. timeout).
    // If the previous access timed out, its late response arrives after drain_dly cycles.
    task automatic do_access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int rdy_dly, input int rsp_dly, input logic [31:0] rdat,
                             input logic rerr, input int hold_n, input int drain_dly);
        int   stall_n = 0, hs_n = 0, err_n = 0, wait_n = 0, rdy_cnt = 0, drain_cnt = 0, cyc = 0;
        bit   in_drain = late_pending;
        bit   tmo = (rsp_dly >= TMO);
        int   exp_wait = tmo ? TMO : rsp_dly + 1;
        int   exp_stall = 2 + rdy_dly + exp_wait + (late_pending ? drain_dly + 1 : 0);
        logic exp_err = tmo ? 1'b1 : rerr;
        bit   done = 0;

        cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        cpu_hold = (hold_n > 0);
        while (!done && cyc < 300) begin
            req_ready = req_valid && (rdy_cnt >= rdy_dly);
            if (in_drain) begin
                rsp_valid = rsp_ready && (drain_cnt == drain_dly);
                rsp_data  = 32'hBAD0_0BAD;
                rsp_err   = 1'b0;
            end else begin
                rsp_valid = rsp_ready && !tmo && (wait_n == rsp_dly);
                rsp_data  = rdat;
                rsp_err   = rerr;
            end
            @(negedge clk);
            if (req_valid) begin
                check("req_fields", {req_write, req_wstrb, req_addr, req_wdata},
                      {(we != 4'b0), we, addr, wdata});
                rdy_cnt++;
                if (req_ready) hs_n++;
            end
            if (in_drain) begin
                if (rsp_ready) begin
                    if (rsp_valid) in_drain = 0;
                    else drain_cnt++;
                end
            end else if (rsp_ready) begin
                wait_n++;
            end
            if (cpu_err) err_n++;
            if (cpu_stall) begin
                stall_n++;
                check("rdata_stable", cpu_rdata, exp_rdata);
                @(posedge clk); #1;
                cyc++;
            end else begin
                done = 1;
                check("err_at_done", cpu_err, exp_err);
            end
        end
        check("completion", done, 1'b1);
        if (!done) begin
            $display("FAIL no_completion: access to %0h never finished", addr);
            $fatal(1, "bench aborted");
        end
        if (we == 4'b0 && !tmo) exp_rdata = rerr ? 32'h0 : rdat;
        check("rdata_done", cpu_rdata, exp_rdata);
        for (int i = 0; i < hold_n; i++) begin
            @(posedge clk); #1;
            if (i == hold_n - 1) cpu_hold = 1'b0;
            @(negedge clk);
            if (cpu_err) err_n++;
            check("hold_state", {cpu_stall, req_valid, cpu_rdata}, {2'b00, exp_rdata});
        end
        @(posedge clk); #1;
        cpu_en = 1'b0; cpu_hold = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        @(negedge clk);
        if (cpu_err) err_n++;
        check("stall_cycles", stall_n, exp_stall);
        check("handshakes", hs_n, 1);
        check("err_pulses", err_n, exp_err);
        check("rdata_wb", {cpu_stall, req_valid, cpu_rdata}, {2'b00, exp_rdata});
        @(posedge clk); #1;
        late_pending = tmo;
    endtask

    task automatic reset_in_wait();
        int cyc = 0;
        cpu_en = 1'b1; cpu_we = 4'b0; cpu_addr = 32'h0000_0040; cpu_hold = 1'b0;
        rsp_valid = 1'b0;
        while (!rsp_ready && cyc < 20) begin
            req_ready = req_valid;
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_wait", rsp_ready, 1'b1);
        req_ready = 1'b0; cpu_en = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_wait", {req_valid, rsp_ready, cpu_stall, cpu_err, cpu_rdata}, '0);
        exp_rdata = 32'h0;
        late_pending = 0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r_we;
        logic [31:0] r_addr, r_wdata, r_rdat;
        int          r_rdy, r_rsp, r_hold, r_drain;
        logic        r_err;

        rst = 1'b1; cpu_en = 1'b0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0; cpu_hold = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
        exp_rdata = 32'h0; late_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", {cpu_rdata, cpu_stall, cpu_err, req_valid, rsp_ready,
                                req_write, req_wstrb, req_addr, req_wdata}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_access(4'b0000, 32'h8000_0010, 32'h0, 0, 3, 32'hDEAD_BEEF, 1'b0, 0, 0);
        do_access(4'b0000, 32'h8000_0020, 32'h0, 0, 0, 32'h1111_2222, 1'b0, 0, 0);
        do_access(4'b0011, 32'h8000_0100, 32'h1234_5678, 4, 1, 32'hFFFF_0000, 1'b0, 0, 0);
        do_access(4'b0000, 32'h8000_0030, 32'h0, 1, 1, 32'hCAFE_0001, 1'b0, 3, 0);
        do_access(4'b0000, 32'h0000_0004, 32'h0, 0, 2, 32'hFFFF_FFFF, 1'b1, 0, 0);
        do_access(4'b0000, 32'h8000_0040, 32'h0, 0, 100, 32'h5555_AAAA, 1'b0, 0, 0);
        do_access(4'b0000, 32'h8000_0044, 32'h0, 0, 1, 32'h0BAD_CAFE, 1'b0, 0, 2);
        do_access(4'b1111, 32'h8000_0048, 32'hA5A5_5A5A, 1, 100, 32'h0, 1'b0, 2, 0);
        do_access(4'b1100, 32'h8000_004C, 32'h0F0F_F0F0, 0, 0, 32'h0, 1'b0, 0, 3);
        do_access(4'b0000, 32'h8000_0050, 32'h0, 0, 1, 32'h7777_8888, 1'b0, 0, 0);
        reset_in_wait();

        for (int k = 0; k < 60; k++) begin
            r_we    = ($urandom_range(1, 0) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
            r_addr  = $urandom() & 32'hFFFF_FFFC;
            r_wdata = $urandom();
            r_rdat  = $urandom();
            r_rdy   = $urandom_range(3, 0);
            r_rsp   = ($urandom_range(9, 0) == 0) ? TMO + $urandom_range(3, 0) : $urandom_range(4, 0);
            r_err   = ($urandom_range(7, 0) == 0);
            r_hold  = $urandom_range(2, 0);
            r_drain = $urandom_range(3, 0);
            do_access(r_we, r_addr, r_wdata, r_rdy, r_rsp, r_rdat, r_err, r_hold, r_drain);
        end
        if (late_pending) begin
            do_access(4'b0000, 32'h8000_0060, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
